// File: rtl/dds_lut_pkg.sv
// Shared definitions for the ping-pong DDS lookup table: CSR offsets and
// the per-channel swap state encoding.
package dds_lut_pkg;

    localparam logic [1:0] CSR_SWAP   = 2'd0;
    localparam logic [1:0] CSR_FORCE  = 2'd1;
    localparam logic [1:0] CSR_ACTIVE = 2'd2;
    localparam logic [1:0] CSR_ERR    = 2'd3;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/dds_lut_bank_ram.sv
// Two-bank table RAM for one DDS channel: port A is the CPU byte-enable
// read/write port, port B the DDS read port. The bank is the address MSB.
module dds_lut_bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic [ADDR_W:0]       a_addr_i,
    input  logic                  a_we_i,
    input  logic [DATA_W/8-1:0]   a_be_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    output logic [DATA_W-1:0]     a_rdata_o,
    input  logic [ADDR_W:0]       b_addr_i,
    output logic [DATA_W-1:0]     b_rdata_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   a_addr_q;
    logic [ADDR_W:0]   b_addr_q;

    // Registered read addresses and byte-lane writes on port A.
    always_ff @(posedge clk_i) begin
        a_addr_q <= a_addr_i;
        b_addr_q <= b_addr_i;
        if (a_we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (a_be_i[b]) begin
                    mem_q[a_addr_i][b*8 +: 8] <= a_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign a_rdata_o = mem_q[a_addr_q];
    assign b_rdata_o = mem_q[b_addr_q];

endmodule

// File: rtl/dds_lut_pingpong.sv
// Multi-channel DDS sample table with an active/shadow bank pair per channel;
// the CPU fills the shadow bank and the swap is committed on a phase wrap.
module dds_lut_pingpong
    import dds_lut_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 10,
    parameter  int NCH    = 2,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CH_W+ADDR_W:0]    avs_address,
    input  logic                    avs_write,
    input  logic                    avs_read,
    input  logic [DATA_W-1:0]       avs_writedata,
    input  logic [DATA_W/8-1:0]     avs_byteenable,
    output logic [DATA_W-1:0]       avs_readdata,
    input  logic [NCH*ADDR_W-1:0]   dds_phase,
    input  logic [NCH-1:0]          dds_wrap,
    output logic [NCH*DATA_W-1:0]   dds_data
);

    logic              is_csr_s;
    logic [CH_W-1:0]   ch_s;
    logic [ADDR_W-1:0] idx_s;
    logic [1:0]        csr_s;
    logic              ch_ok_s;
    logic              wr_tbl_s;
    logic              wr_csr_s;
    logic              rd_s;

    assign is_csr_s = avs_address[CH_W+ADDR_W];
    assign ch_s     = avs_address[ADDR_W +: CH_W];
    assign idx_s    = avs_address[ADDR_W-1:0];
    assign csr_s    = avs_address[1:0];
    assign ch_ok_s  = (int'(ch_s) < NCH);
    assign wr_tbl_s = reset_n & avs_write & ~is_csr_s & ch_ok_s;
    assign wr_csr_s = avs_write & is_csr_s;
    assign rd_s     = avs_read & ~avs_write;

    swap_state_e       state_q [NCH];
    logic [NCH-1:0]    active_q;
    logic [NCH-1:0]    err_q;
    logic [NCH-1:0]    pending_s;
    logic [NCH-1:0]    swap_s;
    logic [NCH-1:0]    force_s;
    logic [NCH-1:0]    clr_s;
    logic [NCH-1:0]    hit_s;
    logic [NCH-1:0]    we_s;

    // Per-channel decode of CSR strobes and table-write targets.
    always_comb begin
        pending_s = '0;
        swap_s    = '0;
        force_s   = '0;
        clr_s     = '0;
        hit_s     = '0;
        we_s      = '0;
        for (int c = 0; c < NCH; c++) begin
            pending_s[c] = (state_q[c] == SWAP_PENDING);
            swap_s[c]    = wr_csr_s && (csr_s == CSR_SWAP)  && avs_writedata[c];
            force_s[c]   = wr_csr_s && (csr_s == CSR_FORCE) && avs_writedata[c];
            clr_s[c]     = wr_csr_s && (csr_s == CSR_ERR)   && avs_writedata[c];
            hit_s[c]     = wr_tbl_s && (int'(ch_s) == c);
            we_s[c]      = hit_s[c] && !pending_s[c];
        end
    end

    // Swap FSM, bank selection and sticky write-while-pending errors.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= SWAP_IDLE;
            end
            active_q <= '0;
            err_q    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                case (state_q[c])
                    SWAP_IDLE: begin
                        if (force_s[c]) begin
                            active_q[c] <= ~active_q[c];
                        end else if (swap_s[c]) begin
                            state_q[c] <= SWAP_PENDING;
                        end else begin
                            state_q[c] <= SWAP_IDLE;
                        end
                    end
                    SWAP_PENDING: begin
                        // FORCE and wrap together still toggle only once
                        if (force_s[c] || dds_wrap[c]) begin
                            active_q[c] <= ~active_q[c];
                            state_q[c]  <= SWAP_IDLE;
                        end else begin
                            state_q[c] <= SWAP_PENDING;
                        end
                    end
                    default: state_q[c] <= SWAP_IDLE;
                endcase
                if (hit_s[c] && pending_s[c]) begin
                    err_q[c] <= 1'b1;
                end else if (clr_s[c]) begin
                    err_q[c] <= 1'b0;
                end else begin
                    err_q[c] <= err_q[c];
                end
            end
        end
    end

    logic [DATA_W-1:0] csr_val_s;

    // CSR read multiplexer; unused bits read as zero.
    always_comb begin
        csr_val_s = '0;
        case (csr_s)
            CSR_SWAP:   csr_val_s[NCH-1:0] = pending_s;
            CSR_FORCE:  csr_val_s = '0;
            CSR_ACTIVE: csr_val_s[NCH-1:0] = active_q;
            CSR_ERR:    csr_val_s[NCH-1:0] = err_q;
            default:    csr_val_s = '0;
        endcase
    end

    logic [DATA_W-1:0] a_rdata_s [NCH];
    logic [DATA_W-1:0] b_rdata_s [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dds_lut_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk_i     (clk),
            .a_addr_i  ({~active_q[g], idx_s}),
            .a_we_i    (we_s[g]),
            .a_be_i    (avs_byteenable),
            .a_wdata_i (avs_writedata),
            .a_rdata_o (a_rdata_s[g]),
            .b_addr_i  ({active_q[g], dds_phase[g*ADDR_W +: ADDR_W]}),
            .b_rdata_o (b_rdata_s[g])
        );
    end

    logic              rd_tbl_q;
    logic [CH_W-1:0]   rd_ch_q;
    logic [DATA_W-1:0] csr_rdata_q;
    logic              live_q;

    // Read-response bookkeeping; live_q forces outputs to zero through reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_tbl_q    <= 1'b0;
            rd_ch_q     <= '0;
            csr_rdata_q <= '0;
            live_q      <= 1'b0;
        end else begin
            rd_tbl_q    <= rd_s & ~is_csr_s & ch_ok_s;
            rd_ch_q     <= ch_s;
            csr_rdata_q <= (rd_s & is_csr_s) ? csr_val_s : '0;
            live_q      <= 1'b1;
        end
    end

    // Output steering for CPU read data and per-channel DDS samples.
    always_comb begin
        if (rd_tbl_q) begin
            avs_readdata = a_rdata_s[rd_ch_q];
        end else begin
            avs_readdata = csr_rdata_q;
        end
        dds_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (live_q) begin
                dds_data[c*DATA_W +: DATA_W] = b_rdata_s[c];
            end else begin
                dds_data[c*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: doc/dds_lut_pingpong.md
DDS_LUT_PINGPONG -- requirements
Module: dds_lut_pingpong

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits; must be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, table depth is 2^ADDR_W words per bank.
REQ-003 Parameter NCH, default 2, number of independent DDS channels; CH_W = max(1, clog2(NCH)).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 avs_address  in  1+CH_W+ADDR_W  MSB=0 selects table {ch, index}; MSB=1 selects CSR, low 2 bits = register.
REQ-008 avs_write / avs_read  in  1 each  Avalon-MM strobes; both high in one cycle is illegal and the write wins.
REQ-009 avs_writedata  in  DATA_W  write data.
REQ-010 avs_byteenable  in  DATA_W/8  byte lanes for table writes; ignored for CSR.
REQ-011 avs_readdata  out  DATA_W  read data, fixed read latency 1.
REQ-012 dds_phase  in  NCH*ADDR_W  flattened per-channel table index; channel c is bits [c*ADDR_W +: ADDR_W].
REQ-013 dds_wrap  in  NCH  per-channel phase-accumulator wrap pulse.
REQ-014 dds_data  out  NCH*DATA_W  flattened per-channel sample from the active bank.

Function
REQ-015 Each channel SHALL own two banks, active (read by DDS) and shadow (written/read by CPU), chosen by bit active_sel[c].
REQ-016 dds_data[c] SHALL equal active-bank word at dds_phase[c] sampled one cycle earlier (latency 1, every cycle, no enable).
REQ-017 Table write SHALL update only enabled bytes of the shadow bank of channel ch at index.
REQ-018 Table read SHALL return the shadow-bank word on avs_readdata in the cycle after avs_read.
REQ-019 CSR 0 SWAP: write sets pending[c] for each 1 bit in writedata[NCH-1:0]; read returns pending.
REQ-020 CSR 1 FORCE: write toggles active_sel[c] immediately for each 1 bit and clears pending[c]; read returns 0.
REQ-021 CSR 2 ACTIVE: read-only, returns active_sel; writes ignored.
REQ-022 CSR 3 ERR: read returns sticky err[NCH-1:0]; write-1-to-clear.
REQ-023 Per-channel swap FSM: IDLE -> PENDING on SWAP write bit; PENDING -> IDLE on dds_wrap[c], toggling active_sel[c] at that edge.
REQ-024 dds_wrap[c] in the same cycle as the SWAP write SHALL NOT swap; swap occurs on the next wrap.
REQ-025 Sample read at the phase presented in the wrap cycle SHALL come from the old bank; the next cycle's phase reads the new bank.
REQ-026 Table write to channel c while pending[c]=1 SHALL be dropped and set err[c]; reads remain allowed.
REQ-027 SWAP write to an already pending channel SHALL leave it pending (no error).
REQ-028 FORCE and wrap to the same channel in one cycle: single toggle only.
REQ-029 Unused CSR read bits and reads of ch >= NCH SHALL return 0; writes to ch >= NCH SHALL be ignored.

Reset
REQ-030 On reset_n=0 at a clock edge: active_sel=0, pending=0, err=0, avs_readdata=0, dds_data=0; RAM contents are not cleared.
REQ-031 Reset asserted mid-PENDING SHALL return the FSM to IDLE with no swap.

Structure
REQ-032 Package dds_lut_pkg SHALL hold CSR offsets (SWAP=0, FORCE=1, ACTIVE=2, ERR=3) and the swap-state enum.
REQ-033 One sub-module dds_lut_bank_ram: dual-port RAM, 2*2^ADDR_W x DATA_W, port A byte-enable read/write (CPU), port B read-only (DDS), both registered-address, instantiated NCH times; bank = address MSB.

Verification
REQ-034 Reset, then write 0x1234 to ch0 index 5, read back -> readdata 0x1234 after 1 cycle; dds_data[0] at phase 5 still 0x0000 (old bank, initialised to 0).
REQ-035 SWAP=0x1, then wrap[0] after 10 cycles -> ACTIVE reads 0x1, dds_data[0] at phase 5 = 0x1234 from the cycle after the wrap's phase read.
REQ-036 SWAP=0x1 with wrap[0] in the same cycle -> pending stays 1; next wrap swaps.
REQ-037 While pending[1]=1, write 0xBEEF to ch1 -> not stored, ERR reads 0x2; write ERR 0x2 -> ERR reads 0x0.
REQ-038 byteenable=0b01 write of 0xAAAA over 0x1234 -> 0x12AA.
REQ-039 reset_n low during PENDING, then wrap -> ACTIVE=0, pending=0, dds_data=0x0000 during reset.
